// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the two-master Wishbone arbiter: default bus widths,
// the watchdog timeout default, the outstanding-transaction counter width and
// the arbitration FSM state encoding.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int unsigned WB_ADDR_WIDTH      = 4;
  localparam int unsigned WB_DATA_WIDTH      = 32;
  localparam int unsigned WB_TIMEOUT_CYCLES  = 1024;
  localparam int unsigned OUTSTANDING_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

endpackage : wb_pkg

// File: rtl/wb_watchdog.sv
// -----------------------------------------------------------------------------
// wb_watchdog
// Tracks accepted-but-unacknowledged strobes for the currently granted master
// and flags a hung slave when no ack arrives for TIMEOUT_CYCLES consecutive
// cycles while transactions are outstanding.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   active       in   a master is currently granted
//   accept       in   forwarded strobe taken by the slave (stb & !stall)
//   ack          in   slave ack while a master is granted
//   grant_change in   grant moves next edge; both counters restart
//   expire       out  combinational: watchdog reaches TIMEOUT_CYCLES this edge
// -----------------------------------------------------------------------------
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic accept,
  input  logic ack,
  input  logic grant_change,
  output logic expire
);

  localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [OUTSTANDING_WIDTH-1:0] OUT_MAX = '1;

  logic [OUTSTANDING_WIDTH-1:0] outstanding_q;
  logic [WD_WIDTH-1:0]          wd_q;
  logic                         wd_run;

  // The watchdog only counts while something is in flight and the slave is
  // silent; an ack or an empty pipeline restarts it.
  assign wd_run = active && (outstanding_q != '0) && !ack;
  assign expire = wd_run && (wd_q == WD_LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk) begin
    if (rst || grant_change) begin
      outstanding_q <= '0;
      wd_q          <= '0;
    end else begin
      // Accept and ack in the same cycle cancel out; both ends saturate.
      unique case ({accept, ack})
        2'b10:   if (outstanding_q != OUT_MAX) outstanding_q <= outstanding_q + 1'b1;
        2'b01:   if (outstanding_q != '0)      outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
      wd_q <= wd_run ? wd_q + 1'b1 : '0;
    end
  end

endmodule : wb_watchdog

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Two-master, one-slave Wishbone arbiter with round-robin tie breaking and a
// watchdog that forcibly releases a grant when the slave stops acknowledging.
// A master released by the watchdog is locked out until it drops cyc.
//
// Ports
//   wb_clk_i, wb_rst_i                 clock; synchronous active-high reset
//   mN_wb_cyc_i/stb_i/we_i/adr_i/dat_i master N request (N = 0, 1)
//   mN_wb_dat_o/ack_o/stall_o          master N response (idle: 0/0/1)
//   s_wb_cyc_o/stb_o/we_o/adr_o/dat_o  shared slave request
//   s_wb_dat_i/ack_i/stall_i           shared slave response
//   timeout_o                          one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,

  input  logic                  m0_wb_cyc_i,
  input  logic                  m0_wb_stb_i,
  input  logic                  m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_wb_dat_i,
  output logic [DATA_WIDTH-1:0] m0_wb_dat_o,
  output logic                  m0_wb_ack_o,
  output logic                  m0_wb_stall_o,

  input  logic                  m1_wb_cyc_i,
  input  logic                  m1_wb_stb_i,
  input  logic                  m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_wb_dat_i,
  output logic [DATA_WIDTH-1:0] m1_wb_dat_o,
  output logic                  m1_wb_ack_o,
  output logic                  m1_wb_stall_o,

  output logic                  s_wb_cyc_o,
  output logic                  s_wb_stb_o,
  output logic                  s_wb_we_o,
  output logic [ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [DATA_WIDTH-1:0] s_wb_dat_o,
  input  logic [DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic                  s_wb_ack_i,
  input  logic                  s_wb_stall_i,

  output logic                  timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [1:0] lock_q, lock_d, lock_set;
  logic       timeout_q;
  logic       elig0, elig1;
  logic       expire;
  logic       active;
  logic       grant_change;

  assign elig0 = m0_wb_cyc_i && !lock_q[0];
  assign elig1 = m1_wb_cyc_i && !lock_q[1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_set     = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        // On a tie the master that did not hold the bus last time wins.
        if (elig0 && elig1) state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
        else if (elig0)     state_d = ST_GRANT0;
        else if (elig1)     state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        if (expire) begin
          state_d      = ST_IDLE;
          last_grant_d = 1'b0;
          lock_set[0]  = 1'b1;
        end else if (!m0_wb_cyc_i) begin
          state_d      = elig1 ? ST_GRANT1 : ST_IDLE;
          last_grant_d = 1'b0;
        end
      end
      ST_GRANT1: begin
        if (expire) begin
          state_d      = ST_IDLE;
          last_grant_d = 1'b1;
          lock_set[1]  = 1'b1;
        end else if (!m1_wb_cyc_i) begin
          state_d      = elig0 ? ST_GRANT0 : ST_IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A lock survives only while its master keeps cyc asserted.
    lock_d = lock_set | (lock_q & {m1_wb_cyc_i, m0_wb_cyc_i});
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      lock_q       <= 2'b00;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      timeout_q    <= expire;
    end
  end

  assign timeout_o    = timeout_q;
  assign active       = (state_q != ST_IDLE);
  assign grant_change = (state_d != state_q);

  // ---------------------------------------------------------------------------
  // Bus multiplexing: the granted master sees the slave directly, the other
  // master is held stalled with no ack and zero read data.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_wb_cyc_o    = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_we_o     = 1'b0;
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    m0_wb_dat_o   = '0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_dat_o   = '0;
    m1_wb_ack_o   = 1'b0;
    m1_wb_stall_o = 1'b1;

    unique case (state_q)
      ST_GRANT0: begin
        s_wb_cyc_o    = m0_wb_cyc_i;
        s_wb_stb_o    = m0_wb_stb_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        m0_wb_dat_o   = s_wb_dat_i;
        m0_wb_ack_o   = s_wb_ack_i;
        m0_wb_stall_o = s_wb_stall_i;
      end
      ST_GRANT1: begin
        s_wb_cyc_o    = m1_wb_cyc_i;
        s_wb_stb_o    = m1_wb_stb_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        m1_wb_dat_o   = s_wb_dat_i;
        m1_wb_ack_o   = s_wb_ack_i;
        m1_wb_stall_o = s_wb_stall_i;
      end
      default: ;
    endcase
  end

  // Slave handshakes only count while a master holds the bus.
  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .active       (active),
    .accept       (s_wb_stb_o && !s_wb_stall_i),
    .ack          (active && s_wb_ack_i),
    .grant_change (grant_change),
    .expire       (expire)
  );

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed scenarios followed by a randomized phase. A behavioural model of
// the arbiter (owner, last owner, in-flight count, silent-cycle count, locks)
// predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_dat [2];
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic          s_ack, s_stall, tmo_o;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .m0_wb_cyc_i   (m_cyc[0]),
    .m0_wb_stb_i   (m_stb[0]),
    .m0_wb_we_i    (m_we[0]),
    .m0_wb_adr_i   (m_adr[0]),
    .m0_wb_dat_i   (m_dat[0]),
    .m0_wb_dat_o   (m0_dat_o),
    .m0_wb_ack_o   (m0_ack_o),
    .m0_wb_stall_o (m0_stall_o),
    .m1_wb_cyc_i   (m_cyc[1]),
    .m1_wb_stb_i   (m_stb[1]),
    .m1_wb_we_i    (m_we[1]),
    .m1_wb_adr_i   (m_adr[1]),
    .m1_wb_dat_i   (m_dat[1]),
    .m1_wb_dat_o   (m1_dat_o),
    .m1_wb_ack_o   (m1_ack_o),
    .m1_wb_stall_o (m1_stall_o),
    .s_wb_cyc_o    (s_cyc),
    .s_wb_stb_o    (s_stb),
    .s_wb_we_o     (s_we),
    .s_wb_adr_o    (s_adr),
    .s_wb_dat_o    (s_dat_o),
    .s_wb_dat_i    (s_dat_i),
    .s_wb_ack_i    (s_ack),
    .s_wb_stall_i  (s_stall),
    .timeout_o     (tmo_o)
  );

  // ---------------------------------------------------------------------------
  // Reference model: who owns the bus, who owned it last, how many strobes are
  // in flight, how long the slave has been silent, and who is locked out.
  // ---------------------------------------------------------------------------
  int mdl_own;      // -1 = nobody
  int mdl_last;
  int mdl_out;
  int mdl_silent;
  bit mdl_lock [2];
  bit mdl_tmo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mdat(input int i);
    return (i == 0) ? m0_dat_o : m1_dat_o;
  endfunction
  function automatic logic mack(input int i);
    return (i == 0) ? m0_ack_o : m1_ack_o;
  endfunction
  function automatic logic mstall(input int i);
    return (i == 0) ? m0_stall_o : m1_stall_o;
  endfunction

  task automatic check_outputs();
    chk("tmo", tmo_o, mdl_tmo);
    chk("outstanding", dut.u_watchdog.outstanding_q, mdl_out);
    if (mdl_own < 0) begin
      chk("idle_cyc", s_cyc, 0);
      chk("idle_stb", s_stb, 0);
    end else begin
      chk("fwd_cyc", s_cyc, m_cyc[mdl_own]);
      chk("fwd_stb", s_stb, m_stb[mdl_own]);
      chk("fwd_we",  s_we,  m_we[mdl_own]);
      chk("fwd_adr", s_adr, m_adr[mdl_own]);
      chk("fwd_dat", s_dat_o, m_dat[mdl_own]);
    end
    for (int i = 0; i < 2; i++) begin
      if (i == mdl_own) begin
        chk("own_ack",   mack(i),   s_ack);
        chk("own_stall", mstall(i), s_stall);
        chk("own_dat",   mdat(i),   s_dat_i);
      end else begin
        chk("oth_ack",   mack(i),   0);
        chk("oth_stall", mstall(i), 1);
        chk("oth_dat",   mdat(i),   0);
      end
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    int  nown;
    bit  acc, ack, expired;
    bit  nlock [2];
    if (rst) begin
      mdl_own = -1; mdl_last = 1; mdl_out = 0; mdl_silent = 0;
      mdl_lock[0] = 0; mdl_lock[1] = 0; mdl_tmo = 0;
    end else begin
      nown = mdl_own;
      acc = 0; ack = 0; expired = 0;
      if (mdl_own >= 0) begin
        acc     = m_stb[mdl_own] && !s_stall;
        ack     = s_ack;
        expired = (mdl_out > 0) && !ack && (mdl_silent + 1 == TMO);
      end
      for (int i = 0; i < 2; i++) nlock[i] = mdl_lock[i] && m_cyc[i];
      if (mdl_own < 0) begin
        if (m_cyc[0] && !mdl_lock[0] && m_cyc[1] && !mdl_lock[1])
          nown = (mdl_last == 0) ? 1 : 0;
        else if (m_cyc[0] && !mdl_lock[0]) nown = 0;
        else if (m_cyc[1] && !mdl_lock[1]) nown = 1;
      end else if (expired) begin
        nown = -1;
        mdl_last = mdl_own;
        nlock[mdl_own] = 1;
      end else if (!m_cyc[mdl_own]) begin
        nown = (m_cyc[1-mdl_own] && !mdl_lock[1-mdl_own]) ? 1 - mdl_own : -1;
        mdl_last = mdl_own;
      end
      if (nown != mdl_own) begin
        mdl_out = 0;
        mdl_silent = 0;
      end else begin
        mdl_silent = (mdl_own >= 0 && mdl_out > 0 && !ack) ? mdl_silent + 1 : 0;
        if (acc && !ack && mdl_out < 255) mdl_out++;
        else if (ack && !acc && mdl_out > 0) mdl_out--;
      end
      mdl_tmo = expired;
      mdl_own = nown;
      mdl_lock[0] = nlock[0];
      mdl_lock[1] = nlock[1];
    end
  endtask

  // Entered just after a rising edge with inputs applied; checks this cycle's
  // outputs, then crosses the next edge.
  task automatic cycle();
    #1;
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0; m_adr[i] = '0; m_dat[i] = '0;
    end
    s_ack = 0; s_stall = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    int w, n, g;
    int seq [$];

    clear_inputs();
    rst = 1;
    model_edge();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state: idle, both masters stalled.
    #1;
    chk("rst_s_cyc", s_cyc, 0);
    chk("rst_m0_stall", m0_stall_o, 1);
    chk("rst_m1_stall", m1_stall_o, 1);
    chk("rst_tmo", tmo_o, 0);

    // Single master write.
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_adr[0] = 4'h0; m_dat[0] = 32'h0000_00A5;
    s_dat_i = 32'h1234_5678;
    #1 chk("single_no_cyc_t", s_cyc, 0);
    cycle();
    chk("single_cyc_t1", s_cyc, 1);
    chk("single_dat", s_dat_o, 32'h0000_00A5);
    chk("single_m1_stall", m1_stall_o, 1);
    s_ack = 1;
    #1 chk("single_m0_ack", m0_ack_o, 1);
    chk("single_m0_rdat", m0_dat_o, 32'h1234_5678);
    cycle();
    s_ack = 0; m_stb[0] = 0; m_cyc[0] = 0;
    cycle();
    cycle();

    // Tie after reset goes to master 0, then hands over with no idle cycle.
    do_reset();
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 4'h3;
    m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 4'h9;
    cycle();
    chk("tie_grant0", s_adr, 4'h3);
    m_cyc[0] = 0; m_stb[0] = 0;
    cycle();
    chk("handover_cyc", s_cyc, 1);
    chk("handover_adr", s_adr, 4'h9);
    cycle();

    // Round robin with both masters requesting continuously.
    do_reset();
    m_adr[0] = 4'h1; m_adr[1] = 4'h2;
    for (int i = 0; i < 2; i++) begin m_cyc[i] = 1; m_stb[i] = 1; end
    for (int k = 0; k < 4; k++) begin
      w = 0;
      #1;
      while (s_cyc !== 1'b1 && w < 10) begin cycle(); w++; end
      chk("rr_granted", s_cyc, 1);
      if (k > 0) chk("rr_no_bubble", w, 0);
      g = (s_adr == 4'h1) ? 0 : 1;
      seq.push_back(g);
      s_ack = 1;
      cycle();
      s_ack = 0; m_cyc[g] = 0; m_stb[g] = 0;
      cycle();
      m_cyc[g] = 1; m_stb[g] = 1;
    end
    for (int k = 0; k < 4; k++) chk("rr_order", seq[k], k % 2);

    // Slave stall holds the granted master off without counting a strobe.
    do_reset();
    m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 4'h5;
    cycle();
    s_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_m1", m1_stall_o, 1);
      chk("stall_out0", dut.u_watchdog.outstanding_q, 0);
      cycle();
    end
    s_stall = 0;
    cycle();
    m_stb[1] = 0;
    #1 chk("stall_out1", dut.u_watchdog.outstanding_q, 1);
    s_ack = 1;
    cycle();
    s_ack = 0;
    chk("stall_out_ack", dut.u_watchdog.outstanding_q, 0);
    m_cyc[1] = 0;
    cycle();

    // Watchdog: one accepted strobe, no ack. TMO silent cycles elapse after the
    // accept edge, the pulse is seen in the following cycle.
    do_reset();
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 4'hC;
    cycle();
    cycle();
    m_stb[0] = 0;
    n = 0;
    #1;
    while (tmo_o !== 1'b1 && n < 30) begin cycle(); n++; end
    chk("tmo_seen", tmo_o, 1);
    chk("tmo_latency", n, TMO);
    chk("tmo_idle", s_cyc, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("tmo_locked", s_cyc, 0);
    end
    m_cyc[0] = 0;
    cycle();
    m_cyc[0] = 1;
    cycle();
    chk("tmo_regrant", s_cyc, 1);
    m_cyc[0] = 0;
    cycle();

    // Reset in the middle of a GRANT1 burst with two strobes in flight.
    do_reset();
    m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 4'h7;
    cycle();
    cycle();
    cycle();
    #1 chk("mid_out2", dut.u_watchdog.outstanding_q, 2);
    m_stb[1] = 0;
    rst = 1;
    cycle();
    chk("mid_drop_cyc", s_cyc, 0);
    chk("mid_out0", dut.u_watchdog.outstanding_q, 0);
    rst = 0;
    m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 4'h3;
    cycle();
    chk("mid_tie_m0", s_adr, 4'h3);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) begin
        m_cyc[i] = ($urandom_range(0, 9) < 7);
        m_stb[i] = $urandom_range(0, 1);
        m_we[i]  = $urandom_range(0, 1);
        m_adr[i] = AW'($urandom);
        m_dat[i] = $urandom;
      end
      s_ack   = ($urandom_range(0, 3) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_dat_i = $urandom;
      rst     = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_wb_arbiter
